// File: rtl/hazard_ctrl.sv
// Hazard controller: per-register latency scoreboard for ID-stage stalls,
// EX operand forwarding selects and a saturating stall statistic.

module hazard_sb_entry #(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    output logic [LAT_W-1:0] cnt
);
    // A new issue overwrites any pending count; otherwise count down to zero.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end
endmodule

module hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int LAT_W      = 3,
    parameter int MAX_LAT    = 4,
    parameter int STAT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    input  logic                  id_wr,
    input  logic [REG_ADDR_W-1:0] id_dst,
    input  logic [LAT_W-1:0]      id_lat,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  mem_regwrite,
    input  logic                  mem_memread,
    input  logic [REG_ADDR_W-1:0] mem_dst,
    input  logic                  wb_regwrite,
    input  logic [REG_ADDR_W-1:0] wb_dst,
    output logic                  stall,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  busy,
    output logic [STAT_W-1:0]     stall_cnt
);
    localparam int               NUM_REGS  = 2 ** REG_ADDR_W;
    localparam logic [LAT_W-1:0] MAX_LAT_L = LAT_W'(MAX_LAT);

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    logic [NUM_REGS-1:0][LAT_W-1:0] cnt;
    logic [NUM_REGS-1:0]            load;
    logic [LAT_W-1:0]               eff_lat;
    logic                           rs_hz, rt_hz, waw_hz, live, issue;

    assign eff_lat = (id_lat > MAX_LAT_L) ? MAX_LAT_L : id_lat;

    // r0 is hard-wired zero, so it is never tracked.
    assign cnt[0]  = '0;
    assign load[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_sb
        assign load[r] = issue & id_wr & (id_dst == REG_ADDR_W'(r));
        hazard_sb_entry #(.LAT_W(LAT_W)) u_entry (
            .clk      (clk),
            .rst      (rst),
            .load     (load[r]),
            .load_val (eff_lat),
            .cnt      (cnt[r])
        );
    end

    assign rs_hz  = id_rs_used & (id_rs != '0) & (cnt[id_rs] != '0);
    assign rt_hz  = id_rt_used & (id_rt != '0) & (cnt[id_rt] != '0);
    // An older, slower write to the same register must not retire after ours.
    assign waw_hz = id_wr & (id_dst != '0) & (cnt[id_dst] > eff_lat);

    assign live  = id_valid & ~flush;
    assign stall = live & (rs_hz | rt_hz | waw_hz);
    assign issue = live & ~stall;
    assign busy  = |cnt;

    // Loads are never forwarded from MEM; the scoreboard holds consumers until WB.
    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src);
        logic [1:0] sel;
        sel = FWD_RF;
        if (mem_regwrite && !mem_memread && mem_dst != '0 && mem_dst == src)
            sel = FWD_MEM;
        else if (wb_regwrite && wb_dst != '0 && wb_dst == src)
            sel = FWD_WB;
        return sel;
    endfunction

    assign forward_a = fwd_sel(ex_rs);
    assign forward_b = fwd_sel(ex_rt);

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule
